// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls-and-Cows solver and scorer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bc_pkg;

  typedef logic [3:0] bcd_digit_t;
  // Digit [3] is the leftmost digit, i.e. bits [15:12] of the flat guess.
  typedef bcd_digit_t [3:0] bcd_guess_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_CHECK,
    S_OFFER,
    S_WAIT_SCORE,
    S_WIN,
    S_FAIL
  } state_t;

  localparam bcd_guess_t FIRST_GUESS = 16'h0123;
  localparam bcd_guess_t LAST_CAND   = 16'h9999;

  // Decimal increment: each digit wraps 9->0 and carries into the next digit left.
  function automatic bcd_guess_t bcd_inc(input bcd_guess_t c);
    bcd_guess_t r;
    logic       carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (c[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = c[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // True when any two digits of the candidate repeat.
  function automatic logic has_dup(input bcd_guess_t c);
    logic d;
    d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (c[i] == c[j]) d = 1'b1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bc_score.sv
// Scores one 4-digit BCD guess against another: bulls (same place) and cows (other place).
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module bc_score
  import bc_pkg::*;
(
  input  logic [15:0] guess_a,
  input  logic [15:0] guess_b,
  output logic [2:0]  bulls,
  output logic [2:0]  cows
);

  bcd_guess_t a;
  bcd_guess_t b;

  assign a = guess_a;
  assign b = guess_b;

  // Compare every digit pair; matching positions count as bulls, others as cows.
  always_comb begin
    bulls = 3'd0;
    cows  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (a[i] == b[j]) begin
          if (i == j) bulls = bulls + 3'd1;
          else        cows  = cows + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bc_solver.sv
// Bulls-and-Cows guesser: offers the smallest candidate consistent with all scores so far.
// Latency: start -> guess_valid after 3 edges with empty history; one candidate/history entry per cycle.
// Backpressure: guess and guess_valid hold stable until guess_ready; scores accepted only in WAIT_SCORE.
module bc_solver
  import bc_pkg::*;
#(
  parameter int MAX_TURNS = 8,
  parameter int HIST_AW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        guess_valid,
  input  logic        guess_ready,
  output logic [15:0] guess,
  input  logic        score_valid,
  input  logic [2:0]  score_bulls,
  input  logic [2:0]  score_cows,
  output logic        busy,
  output logic        solved,
  output logic        failed,
  output logic [3:0]  turn_cnt
);

  localparam logic [3:0] MAX_T = 4'(MAX_TURNS);

  state_t           state;
  bcd_guess_t       cand;
  logic [HIST_AW:0] idx;
  logic [HIST_AW:0] hist_cnt;

  bcd_guess_t       hist_guess [MAX_TURNS];
  logic [2:0]       hist_bulls [MAX_TURNS];
  logic [2:0]       hist_cows  [MAX_TURNS];

  logic [2:0]       chk_bulls;
  logic [2:0]       chk_cows;
  logic [HIST_AW-1:0] rd_idx;
  logic [HIST_AW-1:0] wr_idx;

  assign rd_idx = idx[HIST_AW-1:0];
  assign wr_idx = hist_cnt[HIST_AW-1:0];

  // Re-score the candidate as if it were the secret, against the stored guess.
  bc_score u_score (
    .guess_a (hist_guess[rd_idx]),
    .guess_b (cand),
    .bulls   (chk_bulls),
    .cows    (chk_cows)
  );

  // Status flags are a direct decode of the state register.
  assign busy   = (state == S_SEARCH) || (state == S_CHECK) ||
                  (state == S_OFFER)  || (state == S_WAIT_SCORE);
  assign solved = (state == S_WIN);
  assign failed = (state == S_FAIL);

  // History capture: guess on the offer handshake, score when it comes back.
  always_ff @(posedge clk) begin
    if (state == S_OFFER && guess_ready) begin
      hist_guess[wr_idx] <= cand;
    end
    if (state == S_WAIT_SCORE && score_valid) begin
      hist_bulls[wr_idx] <= score_bulls;
      hist_cows[wr_idx]  <= score_cows;
    end
  end

  // Main control: candidate search, history consistency check, offer and score wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cand        <= FIRST_GUESS;
      idx         <= '0;
      hist_cnt    <= '0;
      turn_cnt    <= 4'd0;
      guess       <= 16'h0000;
      guess_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_FAIL: begin
          if (start) begin
            cand     <= FIRST_GUESS;
            hist_cnt <= '0;
            turn_cnt <= 4'd0;
            state    <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          if (has_dup(cand)) begin
            if (cand == LAST_CAND) begin
              state <= S_FAIL;
            end else begin
              cand <= bcd_inc(cand);
            end
          end else begin
            idx   <= '0;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (idx == hist_cnt) begin
            guess       <= cand;
            guess_valid <= 1'b1;
            state       <= S_OFFER;
          end else if (chk_bulls == hist_bulls[rd_idx] && chk_cows == hist_cows[rd_idx]) begin
            idx <= idx + 1'b1;
          end else if (cand == LAST_CAND) begin
            state <= S_FAIL;
          end else begin
            cand  <= bcd_inc(cand);
            state <= S_SEARCH;
          end
        end

        S_OFFER: begin
          if (guess_ready) begin
            guess_valid <= 1'b0;
            turn_cnt    <= turn_cnt + 4'd1;
            state       <= S_WAIT_SCORE;
          end
        end

        S_WAIT_SCORE: begin
          if (score_valid) begin
            hist_cnt <= hist_cnt + 1'b1;
            if (score_bulls == 3'd4) begin
              state <= S_WIN;
            end else if (turn_cnt == MAX_T) begin
              state <= S_FAIL;
            end else if (cand == LAST_CAND) begin
              state <= S_FAIL;
            end else begin
              cand  <= bcd_inc(cand);
              state <= S_SEARCH;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          guess_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bc_solver.sv
// Directed bench for bc_solver: a default instance plus a MAX_TURNS=2 instance on shared inputs.
// Latency: n/a.
// Backpressure: exercises guess_ready stalls in OFFER.
module tb_bc_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        guess_ready;
  logic        score_valid;
  logic [2:0]  score_bulls;
  logic [2:0]  score_cows;

  logic        guess_valid,  guess_valid2;
  logic [15:0] guess,        guess2;
  logic        busy,         busy2;
  logic        solved,       solved2;
  logic        failed,       failed2;
  logic [3:0]  turn_cnt,     turn_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bc_solver u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess       (guess),
    .score_valid (score_valid),
    .score_bulls (score_bulls),
    .score_cows  (score_cows),
    .busy        (busy),
    .solved      (solved),
    .failed      (failed),
    .turn_cnt    (turn_cnt)
  );

  bc_solver #(.MAX_TURNS(2), .HIST_AW(1)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .guess_valid (guess_valid2),
    .guess_ready (guess_ready),
    .guess       (guess2),
    .score_valid (score_valid),
    .score_bulls (score_bulls),
    .score_cows  (score_cows),
    .busy        (busy2),
    .solved      (solved2),
    .failed      (failed2),
    .turn_cnt    (turn_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
  endtask

  task automatic give_score(input logic [2:0] b, input logic [2:0] c);
    score_valid = 1'b1;
    score_bulls = b;
    score_cows  = c;
    tick();
    score_valid = 1'b0;
    score_bulls = 3'd0;
    score_cows  = 3'd0;
  endtask

  task automatic wait_for_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!guess_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, guess_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    int n;

    rst = 1'b1; start = 1'b0; guess_ready = 1'b0;
    score_valid = 1'b0; score_bulls = 3'd0; score_cows = 3'd0;
    tick();
    tick();
    check("rst_gv",     guess_valid, 0);
    check("rst_guess",  guess,       16'h0000);
    check("rst_busy",   busy,        0);
    check("rst_solved", solved,      0);
    check("rst_failed", failed,      0);
    check("rst_turn",   turn_cnt,    0);
    rst = 1'b0;
    tick();

    // Secret 0123: exact latency to the first offer, then immediate win.
    do_start();
    check("t1_busy_n", busy, 1);
    tick();
    check("t1_gv_n1", guess_valid, 0);
    tick();
    check("t1_gv_n2", guess_valid, 1);
    check("t1_guess", guess, 16'h0123);
    accept();
    check("t1_gv_wait", guess_valid, 0);
    check("t1_turn_acc", turn_cnt, 1);
    give_score(3'd4, 3'd0);
    check("t1_solved", solved, 1);
    check("t1_turn", turn_cnt, 1);
    check("t1_busy", busy, 0);
    check("t1_guess_hold", guess, 16'h0123);
    check("t1_solved2", solved2, 1);

    // Secret 4567: 0A0B on 0123 removes digits 0-3, so 4567 is next.
    do_start();
    wait_for_valid(10, "t2_gv1");
    check("t2_guess1", guess, 16'h0123);
    accept();
    give_score(3'd0, 3'd0);
    wait_for_valid(20000, "t2_gv2");
    check("t2_guess2", guess, 16'h4567);
    accept();
    give_score(3'd4, 3'd0);
    check("t2_solved", solved, 1);
    check("t2_turn", turn_cnt, 2);
    check("t2_solved2", solved2, 1);
    check("t2_turn2", turn_cnt2, 2);

    // Backpressure in OFFER, then scores that leave no candidate.
    do_start();
    wait_for_valid(10, "t3_gv1");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_gv", guess_valid, 1);
      check("bp_guess", guess, 16'h0123);
    end
    check("bp_turn_stall", turn_cnt, 0);
    // A score coinciding with the handshake must be ignored.
    score_valid = 1'b1; score_bulls = 3'd4;
    accept();
    score_valid = 1'b0; score_bulls = 3'd0;
    check("bp_turn_acc", turn_cnt, 1);
    check("bp_gv_drop", guess_valid, 0);
    check("hs_score_ign", solved, 0);
    tick();
    tick();
    check("bp_turn_once", turn_cnt, 1);
    check("bp_busy", busy, 1);
    do_start();
    check("start_ign_turn", turn_cnt, 1);
    check("start_ign_busy", busy, 1);
    give_score(3'd0, 3'd0);
    wait_for_valid(20000, "t3_gv2");
    check("t3_guess2", guess, 16'h4567);
    accept();
    give_score(3'd0, 3'd0);
    check("mt2_failed", failed2, 1);
    check("mt2_turn", turn_cnt2, 2);
    check("t3_busy_search", busy, 1);
    saw_valid = 1'b0;
    n = 0;
    while (!failed && n < 30000) begin
      if (guess_valid || guess_valid2) saw_valid = 1'b1;
      tick();
      n++;
    end
    check("t3_failed", failed, 1);
    check("t3_turn", turn_cnt, 2);
    check("t3_busy", busy, 0);
    check("t3_no_third_gv", saw_valid, 0);
    check("mt2_failed_hold", failed2, 1);

    // Reset in WAIT_SCORE, stray score while IDLE, then a fresh game.
    do_start();
    wait_for_valid(10, "t4_gv1");
    accept();
    check("t4_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_gv",     guess_valid, 0);
    check("t4_rst_guess",  guess,       16'h0000);
    check("t4_rst_busy",   busy,        0);
    check("t4_rst_solved", solved,      0);
    check("t4_rst_failed", failed,      0);
    check("t4_rst_turn",   turn_cnt,    0);
    check("t4_rst_failed2", failed2,    0);
    give_score(3'd4, 3'd0);
    check("idle_score_busy",   busy,     0);
    check("idle_score_solved", solved,   0);
    check("idle_score_turn",   turn_cnt, 0);
    do_start();
    tick();
    tick();
    check("t4_regv", guess_valid, 1);
    check("t4_reguess", guess, 16'h0123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
